// File: rtl/ddr3_pw_pkg.sv
// rtl/ddr3_pw_pkg.sv - shared encodings, states and helpers for the partial-write test controller
package ddr3_pw_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam logic [1:0] MODE_WR_RD   = 2'd0;
    localparam logic [1:0] MODE_WR_ONLY = 2'd1;
    localparam logic [1:0] MODE_RD_ONLY = 2'd2;

    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ACT_W, ST_RCD_W, ST_WR, ST_WAIT_WR, ST_PRE_W, ST_RP_W, ST_RETAIN,
        ST_ACT_R, ST_RCD_R, ST_RD, ST_WAIT_DATA, ST_PRE_R, ST_RP_R, ST_FIN
    } state_t;

    function automatic logic [15:0] byte_diff(input logic [127:0] a, input logic [127:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = |(a[8*i +: 8] ^ b[8*i +: 8]);
        return r;
    endfunction

endpackage

// File: rtl/ddr3_pw_timer.sv
// rtl/ddr3_pw_timer.sv - loadable saturating down-counter with zero flag
module ddr3_pw_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ddr3_pw_test_ctrl.sv
// rtl/ddr3_pw_test_ctrl.sv - issues ACT/WRITE/PRE/retain/ACT/READ/PRE and compares the read-back
module ddr3_pw_test_ctrl
    import ddr3_pw_pkg::*;
#(
    parameter int T_RCD_CYC  = 2,
    parameter int T_WR_CYC   = 10,
    parameter int T_RP_CYC   = 2,
    parameter int RD_TIMEOUT = 64,
    parameter int DDR_ROW_W  = 15,
    parameter int DDR_COL_W  = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 init_done_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [2:0]           bank_i,
    input  logic [DDR_ROW_W-1:0] row_i,
    input  logic [DDR_COL_W-1:0] col_i,
    input  logic [127:0]         pattern_i,
    input  logic [15:0]          wrmask_i,
    input  logic                 pw_en_i,
    input  logic [2:0]           pw_cycles_i,
    input  logic [31:0]          wait_cycles_i,
    input  logic                 accept_i,
    input  logic [127:0]         rddata_i,
    input  logic                 rddata_valid_i,
    output logic [3:0]           command_o,
    output logic [DDR_ROW_W-1:0] address_o,
    output logic [2:0]           bank_o,
    output logic [127:0]         wrdata_o,
    output logic [15:0]          wrdata_mask_o,
    output logic                 partial_write_en_o,
    output logic [2:0]           partial_write_cycles_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [127:0]         rd_data_o,
    output logic [15:0]          mismatch_o
);

    state_t               state_q, state_d;
    logic [1:0]           mode_q;
    logic [2:0]           bank_q;
    logic [DDR_ROW_W-1:0] row_q;
    logic [DDR_COL_W-1:0] col_q;
    logic [127:0]         pattern_q;
    logic [15:0]          mask_q;
    logic                 pw_en_q;
    logic [2:0]           pw_cyc_q;
    logic [31:0]          wait_q;
    logic [127:0]         rd_data_q;
    logic [15:0]          mismatch_q;
    logic                 timeout_q;

    logic                 st_load, st_zero, lt_load, lt_zero;
    logic [7:0]           st_val;
    logic [31:0]          lt_val;
    logic                 capture, rd_timeout, start_ok;
    logic [DDR_ROW_W-1:0] col_addr;

    assign start_ok = (state_q == ST_IDLE) && start_i && init_done_i;

    // Short timer covers tRCD/tWR/tRP; the long one covers retention and the read timeout.
    ddr3_pw_timer #(.W(8)) u_short_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (st_load),
        .load_val_i (st_val),
        .zero_o     (st_zero)
    );

    ddr3_pw_timer #(.W(32)) u_long_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (lt_load),
        .load_val_i (lt_val),
        .zero_o     (lt_zero)
    );

    always_comb begin
        state_d    = state_q;
        st_load    = 1'b0;
        st_val     = '0;
        lt_load    = 1'b0;
        lt_val     = '0;
        capture    = 1'b0;
        rd_timeout = 1'b0;
        case (state_q)
            ST_IDLE:    if (start_ok) state_d = (mode_i == MODE_RD_ONLY) ? ST_ACT_R : ST_ACT_W;
            ST_ACT_W:   if (accept_i) begin st_load = 1'b1; st_val = 8'(T_RCD_CYC); state_d = ST_RCD_W; end
            ST_RCD_W:   if (st_zero) state_d = ST_WR;
            ST_WR:      if (accept_i) begin st_load = 1'b1; st_val = 8'(T_WR_CYC); state_d = ST_WAIT_WR; end
            ST_WAIT_WR: if (st_zero) state_d = ST_PRE_W;
            ST_PRE_W:   if (accept_i) begin st_load = 1'b1; st_val = 8'(T_RP_CYC); state_d = ST_RP_W; end
            ST_RP_W: begin
                if (st_zero) begin
                    if (mode_q == MODE_WR_ONLY) begin
                        state_d = ST_FIN;
                    end else if (wait_q != '0) begin
                        lt_load = 1'b1;
                        lt_val  = wait_q - 32'd1;
                        state_d = ST_RETAIN;
                    end else begin
                        state_d = ST_ACT_R;
                    end
                end
            end
            ST_RETAIN:  if (lt_zero) state_d = ST_ACT_R;
            ST_ACT_R:   if (accept_i) begin st_load = 1'b1; st_val = 8'(T_RCD_CYC); state_d = ST_RCD_R; end
            ST_RCD_R:   if (st_zero) state_d = ST_RD;
            ST_RD:      if (accept_i) begin lt_load = 1'b1; lt_val = 32'(RD_TIMEOUT - 1); state_d = ST_WAIT_DATA; end
            ST_WAIT_DATA: begin
                if (rddata_valid_i) begin
                    capture = 1'b1;
                    state_d = ST_PRE_R;
                end else if (lt_zero) begin
                    rd_timeout = 1'b1;
                    state_d    = ST_PRE_R;
                end
            end
            ST_PRE_R:   if (accept_i) begin st_load = 1'b1; st_val = 8'(T_RP_CYC); state_d = ST_RP_R; end
            ST_RP_R:    if (st_zero) state_d = ST_FIN;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_addr                 = '0;
        col_addr[DDR_COL_W-1:0]  = col_q;
        col_addr[A10_BIT]        = 1'b0;
        command_o                = CMD_NOP;
        address_o                = '0;
        bank_o                   = '0;
        case (state_q)
            ST_ACT_W, ST_ACT_R: begin command_o = CMD_ACT;   address_o = row_q;    bank_o = bank_q; end
            ST_WR:              begin command_o = CMD_WRITE; address_o = col_addr; bank_o = bank_q; end
            ST_RD:              begin command_o = CMD_READ;  address_o = col_addr; bank_o = bank_q; end
            ST_PRE_W, ST_PRE_R: begin command_o = CMD_PRE;   bank_o = bank_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WR_RD;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pattern_q  <= '0;
            mask_q     <= 16'hFFFF;
            pw_en_q    <= 1'b0;
            pw_cyc_q   <= '0;
            wait_q     <= '0;
            rd_data_q  <= '0;
            mismatch_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                mode_q     <= (mode_i == 2'd3) ? MODE_WR_RD : mode_i;
                bank_q     <= bank_i;
                row_q      <= row_i;
                col_q      <= col_i;
                pattern_q  <= pattern_i;
                mask_q     <= wrmask_i;
                pw_en_q    <= pw_en_i;
                pw_cyc_q   <= pw_cycles_i;
                wait_q     <= wait_cycles_i;
                mismatch_q <= '0;
                timeout_q  <= 1'b0;
            end
            // Every byte is compared; the write mask only affects what the sequencer writes.
            if (capture) begin
                rd_data_q  <= rddata_i;
                mismatch_q <= byte_diff(rddata_i, pattern_q);
            end
            if (rd_timeout) begin
                timeout_q  <= 1'b1;
                mismatch_q <= 16'hFFFF;
            end
        end
    end

    assign wrdata_o               = pattern_q;
    assign wrdata_mask_o          = mask_q;
    assign partial_write_en_o     = pw_en_q;
    assign partial_write_cycles_o = pw_cyc_q;
    assign busy_o                 = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done_o                 = (state_q == ST_FIN);
    assign timeout_o              = timeout_q;
    assign rd_data_o              = rd_data_q;
    assign mismatch_o             = mismatch_q;

endmodule

// File: doc/ddr3_pw_test_ctrl.md
Name: ddr3_pw_test_ctrl

Overview:
- Command-issuing stage directly upstream of the partial-write DFI sequencer wrapper.
- Turns one host test request into a complete DDR3 command sequence: ACT, WRITE (optionally partial), PRE, retention wait with no refresh, ACT, READ, PRE.
- Captures the 128-bit read-back and reports per-byte mismatches against the written pattern.
- Holds the sequencer's command/address/bank/wrdata/mask/partial-write inputs and obeys its accept handshake.

Parameters:
- T_RCD_CYC, 2: idle cycles after an accepted ACT before the column command.
- T_WR_CYC, 10: idle cycles after an accepted WRITE before PRE (covers write latency + burst + tWR).
- T_RP_CYC, 2: idle cycles after an accepted PRE.
- RD_TIMEOUT, 64: maximum cycles to wait for rddata_valid after an accepted READ.
- DDR_ROW_W, 15: row address width.
- DDR_COL_W, 9: column address width.

Ports:
- clk_i  in  1  sole clock.
- rst_n_i  in  1  asynchronous active-low reset.
- init_done_i  in  1  DRAM initialisation complete; start_i is ignored while low.
- start_i  in  1  launch a test; sampled only in IDLE.
- mode_i  in  2  0=write+read, 1=write only, 2=read only, 3=reserved (treated as 0).
- bank_i  in  3  target bank.
- row_i  in  15  target row.
- col_i  in  9  target column.
- pattern_i  in  128  write data / expected data.
- wrmask_i  in  16  byte mask; 1 = byte not written.
- pw_en_i  in  1  partial-write enable.
- pw_cycles_i  in  3  partial-write cycle count.
- wait_cycles_i  in  32  retention wait length in cycles; 0 = no wait.
- accept_i  in  1  sequencer accepted the current command.
- rddata_i  in  128  sequencer read data.
- rddata_valid_i  in  1  read data valid.
- command_o  out  4  {cs_n,ras_n,cas_n,we_n}.
- address_o  out  15  DDR address.
- bank_o  out  3  DDR bank.
- wrdata_o  out  128  write data.
- wrdata_mask_o  out  16  write byte mask.
- partial_write_en_o  out  1  partial-write enable to the sequencer.
- partial_write_cycles_o  out  3  partial-write cycle count to the sequencer.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.
- timeout_o  out  1  read-back timed out (sticky until next start).
- rd_data_o  out  128  captured read data.
- mismatch_o  out  16  per-byte compare result; bit i = byte i of rd_data differs from pattern.

Behaviour:
- Interface: one clock clk_i; reset rst_n_i is asynchronous and active-low.
- Command encodings: NOP=0111, ACT=0011, WRITE=0100, READ=0101, PRE=0010. REFRESH is never issued.
- Reset values:
  - command_o=NOP; address_o, bank_o, wrdata_o, rd_data_o = 0.
  - wrdata_mask_o=FFFF; partial_write_en_o=0; partial_write_cycles_o=0.
  - busy_o, done_o, timeout_o = 0; mismatch_o=0; FSM=IDLE.
- Reset mid-operation aborts immediately to IDLE with the reset values; no closing PRE is issued.
- Start: in IDLE with start_i=1 and init_done_i=1:
  - Register all request inputs; wrdata/mask/pw outputs hold them until the next start.
  - Set busy_o; clear timeout_o and mismatch_o.
  - start_i while busy is ignored.
- Issue rule:
  - A command state drives its command, address and bank from the registered cycle onward, held stable until the cycle accept_i=1.
  - On the next cycle command_o=NOP and the timing counter loads its parameter.
  - The wait state exits when the counter reaches 0; a parameter of 0 gives 1 NOP cycle.
- FSM:
  - IDLE -> ACT_W (mode 0/1) or ACT_R (mode 2).
  - Write phase: ACT_W(address=row) -> WAIT_RCD -> WR(address={A10=0, col zero-extended}) -> WAIT_WR -> PRE_W(A10=0) -> WAIT_RP.
  - Mode 1 goes to FIN after WAIT_RP. Mode 0 goes to RETAIN if wait_cycles>0, else to ACT_R.
  - RETAIN counts wait_cycles cycles exactly (32-bit down-counter), emitting NOP throughout.
  - Read phase: ACT_R -> WAIT_RCD -> RD -> WAIT_DATA -> PRE_R -> WAIT_RP -> FIN.
  - FIN: done_o=1 for one cycle, busy_o=0, return to IDLE.
- WAIT_DATA:
  - On rddata_valid_i, capture rd_data_o and set mismatch_o[i] = |(rd_data[8i+7:8i] ^ pattern[8i+7:8i]).
  - All bytes are compared, regardless of mask.
  - If RD_TIMEOUT cycles elapse without valid: set timeout_o, mismatch_o=FFFF, continue to PRE_R.
  - rddata_valid_i outside WAIT_DATA is ignored.
- Accept semantics: accept_i while command_o=NOP has no effect. A stalled accept holds the command indefinitely; there is no issue timeout.

Decomposition:
- Shared package ddr3_pw_pkg:
  - Command encodings.
  - Mode values.
  - FSM state enum.
  - A10 bit index.
- One natural sub-module: ddr3_pw_timer, a loadable down-counter with a zero flag. It is used for the tRCD/tWR/tRP waits, with a separate 32-bit instance for RETAIN and RD_TIMEOUT.

Test Plan:
- Accept always 1, mode 0, bank 3, row 0x1A2B, col 0x040, wait 0 -> commands ACT(0x1A2B), WRITE(0x040), PRE, ACT, READ, PRE in order. Gaps ≥ T_RCD_CYC/T_WR_CYC/T_RP_CYC. Read data = pattern -> mismatch_o=0000, one done_o pulse.
- Accept delayed 5 cycles on each command -> each command held 6 cycles unchanged, then NOP.
- Mode 0, wait_cycles=1000 -> exactly 1000 NOP cycles between first PRE acceptance+T_RP and the second ACT; no REFRESH ever.
- Read data with byte 5 flipped -> mismatch_o=0020. Valid never returned -> after 64 cycles timeout_o=1, mismatch_o=FFFF, PRE still issued, done_o pulses.
- pw_en=1, pw_cycles=2, mask=00F0 -> partial_write_en_o=1, partial_write_cycles_o=2, wrdata_mask_o=00F0 stable start-to-done. start_i during busy is ignored.
- rst_n_i low during RETAIN -> outputs at reset values asynchronously. init_done_i=0 with start_i=1 -> stays IDLE.
